// File: rtl/stack_pkg.sv
// Shared types and defaults for the stack arbitration front-end.
package stack_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 64;
  localparam int DEF_CNT_W = 7;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    CAP,
    RESP,
    FLUSH
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. grant_next is the combinational pick for
// the current requests; grant is the last accepted winner, which doubles as
// the "current owner" while an operation is in flight.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant_next,
  output logic [1:0] grant
);

  logic [1:0] grant_reg;

  // Lone requester wins outright; on a tie the side not granted last wins.
  always_comb begin
    grant_next = req;
    if (req == 2'b11) begin
      grant_next = grant_reg[0] ? 2'b10 : 2'b01;
    end
  end

  // Last-grant register; reset value points at requester 1 so requester 0
  // wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_reg <= 2'b10;
    end else if (accept && (req != 2'b00)) begin
      grant_reg <= grant_next;
    end
  end

  assign grant = grant_reg;

endmodule

// File: rtl/stack_arbiter.sv
// Arbitration and sequencing front-end for the shared hardware stack port.
// Tracks occupancy itself, rejects overflow/underflow without touching the
// stack, sequences flushes and captures pop data one cycle after the strobe.
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             op0,
  input  logic             op1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             ack0,
  output logic             ack1,
  output logic             err0,
  output logic             err1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  input  logic             flush,
  output logic             flush_done,
  output logic             busy,
  output logic [CNT_W-1:0] depth,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  output logic             stk_reset
);

  state_t           state_reg;
  logic [CNT_W-1:0] depth_reg;
  logic             op_reg;
  logic [WIDTH-1:0] wdata_reg;
  logic             push_reg;
  logic             pop_reg;
  logic             flush_done_reg;
  logic [1:0]       ack_reg;
  logic [1:0]       err_reg;
  logic [WIDTH-1:0] rdata0_reg;
  logic [WIDTH-1:0] rdata1_reg;

  logic [1:0]       grant_next;
  logic [1:0]       grant;
  logic             any_req;
  logic             accept;
  logic             win_op;
  logic [WIDTH-1:0] win_wdata;
  logic             win_legal;

  assign any_req = req0 | req1;
  assign accept  = (state_reg == IDLE) && !flush && any_req;

  rr_arb2 u_arb (
    .clock      (clock),
    .reset      (reset),
    .req        ({req1, req0}),
    .accept     (accept),
    .grant_next (grant_next),
    .grant      (grant)
  );

  // Winner's operation and legality against the authoritative depth count.
  always_comb begin
    win_op    = grant_next[1] ? op1 : op0;
    win_wdata = grant_next[1] ? wdata1 : wdata0;
    if (win_op == OP_PUSH) begin
      win_legal = (depth_reg < CNT_W'(DEPTH));
    end else begin
      win_legal = (depth_reg != '0);
    end
  end

  // Sequencing FSM with all responses and strobes registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      depth_reg      <= '0;
      op_reg         <= OP_PUSH;
      wdata_reg      <= '0;
      push_reg       <= 1'b0;
      pop_reg        <= 1'b0;
      flush_done_reg <= 1'b0;
      ack_reg        <= 2'b00;
      err_reg        <= 2'b00;
      rdata0_reg     <= '0;
      rdata1_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (flush) begin
            state_reg      <= FLUSH;
            flush_done_reg <= 1'b1;
          end else if (any_req) begin
            op_reg    <= win_op;
            wdata_reg <= win_wdata;
            if (win_legal) begin
              state_reg <= EXEC;
              push_reg  <= (win_op == OP_PUSH);
              pop_reg   <= (win_op == OP_POP);
            end else begin
              // Rejected: answer straight away, stack left untouched.
              state_reg <= RESP;
              ack_reg   <= grant_next;
              err_reg   <= grant_next;
            end
          end
        end
        EXEC: begin
          push_reg <= 1'b0;
          pop_reg  <= 1'b0;
          if (op_reg == OP_PUSH) begin
            depth_reg <= depth_reg + 1'b1;
            ack_reg   <= grant;
            state_reg <= RESP;
          end else begin
            depth_reg <= depth_reg - 1'b1;
            state_reg <= CAP;
          end
        end
        CAP: begin
          if (grant[1]) begin
            rdata1_reg <= stk_dout;
          end else begin
            rdata0_reg <= stk_dout;
          end
          ack_reg   <= grant;
          state_reg <= RESP;
        end
        RESP: begin
          ack_reg    <= 2'b00;
          err_reg    <= 2'b00;
          rdata0_reg <= '0;
          rdata1_reg <= '0;
          state_reg  <= IDLE;
        end
        FLUSH: begin
          flush_done_reg <= 1'b0;
          depth_reg      <= '0;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ack0       = ack_reg[0];
  assign ack1       = ack_reg[1];
  assign err0       = err_reg[0];
  assign err1       = err_reg[1];
  assign rdata0     = rdata0_reg;
  assign rdata1     = rdata1_reg;
  assign flush_done = flush_done_reg;
  assign busy       = (state_reg != IDLE);
  assign depth      = depth_reg;
  assign stk_push   = push_reg;
  assign stk_pop    = pop_reg;
  assign stk_din    = wdata_reg;
  assign stk_reset  = reset | (state_reg == FLUSH);

endmodule

// File: tb/tb_stack_arbiter.sv
// Self-checking bench for stack_arbiter: a behavioural stack sits behind the
// DUT, expected responses are queued when requests are issued and popped
// when an ack appears.
module tb_stack_arbiter;
  import stack_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int D  = DEF_DEPTH;
  localparam int CW = DEF_CNT_W;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [W-1:0]  wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, err0, err1;
  logic [W-1:0]  rdata0, rdata1;
  logic          flush = 1'b0;
  logic          flush_done, busy;
  logic [CW-1:0] depth;
  logic          stk_push, stk_pop, stk_reset;
  logic [W-1:0]  stk_din, stk_dout;

  stack_arbiter #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .flush(flush), .flush_done(flush_done), .busy(busy), .depth(depth),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
    .stk_dout(stk_dout), .stk_reset(stk_reset)
  );

  always #5 clock = ~clock;

  int n_checks = 0, n_fail = 0, cyc = 0;
  int push_cnt = 0, pop_cnt = 0, exp_pushes = 0, exp_pops = 0, model_depth = 0;
  logic [W-1:0] model_stk[$];

  typedef struct {
    int          id;
    logic        err;
    logic [15:0] rdata;
    int          dep;
    int          lat;
    int          start;
  } exp_t;
  exp_t sb[$];

  // Behavioural stack: acts on the strobe edge, popped word held on stk_dout.
  logic [W-1:0] mem [0:D-1];
  int           sp = 0;
  logic [W-1:0] dout_q = '0;
  always @(posedge clock) begin
    if (stk_reset) begin
      sp     <= 0;
      dout_q <= '0;
    end else if (stk_push && sp < D) begin
      mem[sp] <= stk_din;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      dout_q <= mem[sp-1];
      sp     <= sp - 1;
    end
  end
  assign stk_dout = dout_q;

  // Cycle counter used for latency measurement.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Predict the response of one request from the reference model.
  task automatic expect_op(input int id, input logic op, input logic [15:0] data, input int extra);
    exp_t e;
    int   base;
    e.id = id; e.start = cyc; e.err = 1'b0; e.rdata = '0;
    if (op == OP_PUSH) begin
      if (model_depth < D) begin
        model_stk.push_back(data); model_depth++; exp_pushes++; base = 2;
      end else begin
        e.err = 1'b1; base = 1;
      end
    end else begin
      if (model_depth > 0) begin
        e.rdata = model_stk.pop_back(); model_depth--; exp_pops++; base = 3;
      end else begin
        e.err = 1'b1; base = 1;
      end
    end
    e.dep = model_depth;
    e.lat = (extra < 0) ? -1 : base + extra;
    sb.push_back(e);
  endtask

  task automatic issue(input int id, input logic op, input logic [15:0] data,
                       input int extra, input bit track);
    @(negedge clock);
    if (id == 0) begin op0 = op; wdata0 = data; req0 = 1'b1; end
    else         begin op1 = op; wdata1 = data; req1 = 1'b1; end
    if (track) expect_op(id, op, data, extra);
  endtask

  task automatic wait_ack(input int id);
    bit got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if ((id == 0 && ack0) || (id == 1 && ack1)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check($sformatf("ack%0d_timeout", id), 32'd0, 32'd1);
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic xact(input int id, input logic op, input logic [15:0] data);
    issue(id, op, data, 0, 1'b1);
    wait_ack(id);
  endtask

  // Scoreboard: every ack is matched against the oldest queued expectation.
  exp_t mon_e;
  int   mon_id;
  always @(negedge clock) begin
    if (stk_push) push_cnt++;
    if (stk_pop)  pop_cnt++;
    if (ack0 || ack1) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        mon_e  = sb.pop_front();
        mon_id = ack1 ? 1 : 0;
        check("ack_onehot", {31'd0, ack0 & ack1}, 32'd0);
        check("ack_id", mon_id, mon_e.id);
        check("err", mon_id ? err1 : err0, {31'd0, mon_e.err});
        check("rdata", mon_id ? rdata1 : rdata0, {16'd0, mon_e.rdata});
        check("depth", {25'd0, depth}, mon_e.dep);
        check("other_side_quiet", mon_id ? {ack0, err0, rdata0} : {ack1, err1, rdata1}, 32'd0);
        if (mon_e.lat >= 0) check("latency", cyc - mon_e.start, mon_e.lat);
        $display("txn: req%0d err=%0b rdata=%04h depth=%0d cycle=%0d",
                 mon_id, mon_id ? err1 : err0, mon_id ? rdata1 : rdata0, depth, cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  int pc;
  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    check("rst_stk_reset", stk_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_depth", depth, 0);
    check("rst_acks", {ack1, ack0, err1, err0}, 0);
    check("rst_strobes", {stk_push, stk_pop, flush_done}, 0);
    check("rst_stk_din", stk_din, 0);
    check("rst_rdata", {rdata1, rdata0}, 0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_release_stk_reset", stk_reset, 0);

    // First push: strobe one cycle after sampling, ack after two
    issue(0, OP_PUSH, 16'hA5A5, 0, 1'b1);
    @(negedge clock);
    check("t1_stk_push", stk_push, 1);
    check("t1_stk_pop", stk_pop, 0);
    check("t1_stk_din", stk_din, 16'hA5A5);
    check("t1_busy", busy, 1);
    wait_ack(0);

    // Pops by requester 1, ending with an underflow
    xact(0, OP_PUSH, 16'h1234);
    xact(1, OP_POP, 16'h0);
    xact(1, OP_POP, 16'h0);
    xact(1, OP_POP, 16'h0);

    // Contention: grants alternate 0,1,0,1
    expect_op(0, OP_PUSH, 16'h1000, -1);
    expect_op(1, OP_PUSH, 16'h1001, -1);
    expect_op(0, OP_PUSH, 16'h1002, -1);
    expect_op(1, OP_PUSH, 16'h1003, -1);
    fork
      begin
        issue(0, OP_PUSH, 16'h1000, -1, 1'b0); wait_ack(0);
        issue(0, OP_PUSH, 16'h1002, -1, 1'b0); wait_ack(0);
      end
      begin
        issue(1, OP_PUSH, 16'h1001, -1, 1'b0); wait_ack(1);
        issue(1, OP_PUSH, 16'h1003, -1, 1'b0); wait_ack(1);
      end
    join
    check("t3_depth", depth, 4);

    // Fill to capacity, then overflow
    for (int i = 0; i < 60; i++) xact(0, OP_PUSH, 16'(16'h2000 + i));
    check("t4_full_depth", depth, 64);
    pc = push_cnt;
    xact(1, OP_PUSH, 16'hDEAD);
    check("t4_no_push_on_overflow", push_cnt, pc);

    // Drain down to 10 entries, checking LIFO order
    for (int i = 0; i < 54; i++) xact(0, OP_POP, 16'h0);
    check("t5_depth10", depth, 10);

    // Flush and pop requested together: flush first, pop then underflows
    @(negedge clock);
    flush = 1'b1; op0 = OP_POP; wdata0 = '0; req0 = 1'b1;
    model_stk.delete(); model_depth = 0;
    expect_op(0, OP_POP, 16'h0, 2);
    @(negedge clock);
    check("t5_stk_reset", stk_reset, 1);
    check("t5_flush_done", flush_done, 1);
    check("t5_no_pop", stk_pop, 0);
    flush = 1'b0;
    @(negedge clock);
    check("t5_depth0", depth, 0);
    check("t5_flush_done_pulse", flush_done, 0);
    wait_ack(0);

    // Flush raised mid-operation is held until IDLE
    issue(0, OP_PUSH, 16'hBEEF, 0, 1'b1);
    @(negedge clock);
    flush = 1'b1;
    wait_ack(0);
    @(negedge clock);
    check("t6_flush_waits", flush_done, 0);
    @(negedge clock);
    check("t6_flush_done", flush_done, 1);
    check("t6_stk_reset", stk_reset, 1);
    flush = 1'b0;
    model_stk.delete(); model_depth = 0;
    @(negedge clock);
    check("t6_depth0", depth, 0);

    // Reset during CAP aborts the pop with no ack
    xact(0, OP_PUSH, 16'h7777);
    issue(1, OP_POP, 16'h0, 0, 1'b0);
    exp_pops++;
    @(negedge clock);
    check("t7_stk_pop", stk_pop, 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t7_no_ack", {ack1, ack0, err1, err0}, 0);
    check("t7_rdata", {rdata1, rdata0}, 0);
    check("t7_depth", depth, 0);
    check("t7_stk_reset", stk_reset, 1);
    check("t7_busy", busy, 0);
    reset = 1'b0; req1 = 1'b0;
    model_stk.delete(); model_depth = 0;
    @(negedge clock);

    // Normal service resumes after the abort
    xact(1, OP_PUSH, 16'hC3C3);
    xact(0, OP_POP, 16'h0);

    repeat (2) @(negedge clock);
    check("sb_drained", sb.size(), 0);
    check("push_strobes", push_cnt, exp_pushes);
    check("pop_strobes", pop_cnt, exp_pops);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Sequencing and arbitration front-end for the 16-bit hardware stack used by the CPU. It shares the stack's single push/pop port between two requesters: requester 0 is call/return, and requester 1 is interrupt entry/exit. It tracks occupancy itself and rejects overflow and underflow. It also sequences a stack flush and captures pop data on the cycle the stack presents it.

## Interface
Parameters:
- WIDTH, 16, data width
- DEPTH, 64, usable stack entries
- CNT_W, 7, width of the occupancy counter (holds 0..DEPTH)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req0 / req1  in  1  request from requester 0 / 1, level, held until ack
- op0 / op1  in  1  0 = push, 1 = pop
- wdata0 / wdata1  in  WIDTH  push data
- ack0 / ack1  out  1  one-cycle completion pulse
- err0 / err1  out  1  valid with ack; 1 = rejected (overflow or underflow)
- rdata0 / rdata1  out  WIDTH  pop data, valid with ack
- flush  in  1  level request to empty the stack
- flush_done  out  1  one-cycle pulse
- busy  out  1  FSM not in IDLE
- depth  out  CNT_W  current occupancy
- stk_push / stk_pop  out  1  stack strobes
- stk_din  out  WIDTH  data to stack
- stk_dout  in  WIDTH  stack output
- stk_reset  out  1  stack clear, equal to reset OR (state == FLUSH)

## Operation
- FSM states:
  - IDLE: sample flush, req0, req1.
  - EXEC: exactly one of stk_push/stk_pop is high.
  - CAP: pop only; stk_dout is valid.
  - RESP: ackN is high.
  - FLUSH: stk_reset is high.
- IDLE priority: flush first, then round-robin between req0 and req1.
  - The last-granted pointer resets so that req0 wins the first tie.
  - A lone requester always wins.
- Grant register latches the winner's op and wdata. stk_din is driven from the latched wdata.
- Legal push (depth < DEPTH): IDLE → EXEC → RESP → IDLE. depth increments at the end of EXEC.
- Legal pop (depth > 0): IDLE → EXEC → CAP → RESP → IDLE. depth decrements at the end of EXEC. rdataN is registered from stk_dout at the end of CAP.
- Illegal request (push when depth == DEPTH, or pop when depth == 0):
  - IDLE → RESP directly.
  - No stack strobe is issued.
  - errN = 1, rdataN = 0, depth unchanged.
- Flush: IDLE → FLUSH → IDLE.
  - depth becomes 0 at the end of FLUSH.
  - flush_done is high during the FLUSH cycle.
  - flush asserted outside IDLE waits; it is not lost.
- Requests are sampled only in IDLE. The requester must have req low in the cycle after ack, otherwise the request is taken as new.
- ack, err and rdata go only to the granted requester. The other requester's outputs stay 0.
- The stack's own empty/full flags are not used. depth is authoritative.

## Timing
- Reset values: state IDLE; all ack, err, rdata, stk_push, stk_pop, stk_din, flush_done and depth are 0; busy = 0; stk_reset = 1 while reset is high.
- Latency from the IDLE sampling edge to the ack cycle:
  - push: 2 cycles
  - pop: 3 cycles
  - rejected request: 1 cycle
  - flush_done: 1 cycle
- Throughput: one push per 3 cycles, one pop per 4 cycles.
- The strobe is high for exactly one cycle. The stack acts on the edge that ends EXEC.
- Reset mid-operation aborts the in-flight operation with no ack. The stack is cleared through stk_reset.
- Simultaneous flush and request in IDLE: flush wins, and the request is served afterwards against depth = 0.

## Structure
- Package stack_pkg holds:
  - state enum (IDLE, EXEC, CAP, RESP, FLUSH)
  - OP_PUSH / OP_POP constants
  - default WIDTH, DEPTH and CNT_W
- Sub-module rr_arb2 is the two-input round-robin arbiter with a last-grant register. Its grant outputs are one-hot and are updated only on an accepted grant.

## Test plan
- Reset, then req0 push 16'hA5A5: stk_push high 1 cycle after sampling, ack0 2 cycles after sampling, err0 = 0, depth = 1.
- req1 pop with the stack holding 16'h1234: ack1 3 cycles after sampling, rdata1 = 16'h1234, depth decrements.
- req0 and req1 both pushing continuously: grants alternate 0, 1, 0, 1 (req0 first after reset); depth reaches 4 after 4 acks.
- 64 pushes, then a 65th: ack with err = 1, no stk_push, depth stays 64. Pop on an empty stack: err = 1, rdata = 0.
- flush with depth = 10 and req0 pending: stk_reset and flush_done pulse 1 cycle, depth = 0, then req0's pop returns err = 1.
- reset asserted during CAP: no ack, all outputs 0 next cycle, depth = 0, stk_reset high.
